store_unit: RTL

- Parametrised RV store execution unit. Successor to the combinational store decoder.
- Decodes S-type fields and computes the effective address.
- Produces lane-aligned write data and byte enables, then runs a valid/ready request and response transaction to the data memory.
- Reports completion and precise exceptions to the core's writeback/trap logic.
- Supports XLEN 32 or 64; SD is legal only when XLEN=64.

---
 rtl/store_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/store_unit.sv
// RV store execution unit: S-type decode, lane alignment and a
// valid/ready memory write transaction with precise exceptions.
module store_unit #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:7]       instruction_code,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_resp_valid,
  input  logic              mem_resp_err,
  output logic              done_valid,
  output logic [XLEN-1:0]   done_addr,
  output logic              exc_illegal,
  output logic              exc_misaligned,
  output logic              exc_access
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t          state, nstate;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm, ea;
  logic [OW-1:0]   off, amask;
  logic [3:0]      nbytes;
  logic            ill, mis;
  logic [NB-1:0]   bsel, be_c;
  logic [XLEN-1:0] dmask, wd_c;
  logic [CW-1:0]   cnt;
  logic            tmo;
  logic            ill_q, mis_q, acc_q;

  assign rs1 = instruction_code[19:15];
  assign rs2 = instruction_code[24:20];
  assign f3  = instruction_code[14:12];
  assign imm = {{(XLEN-12){instruction_code[31]}},
                instruction_code[31:25],
                instruction_code[11:7]};
  assign ea  = rs1_data + imm;
  assign off = ea[OW-1:0];

  always_comb begin
    nbytes = 4'd0;
    amask  = '0;
    ill    = 1'b0;
    case (f3)
      3'b000: nbytes = 4'd1;
      3'b001: begin
        nbytes = 4'd2;
        amask  = OW'(3'd1);
      end
      3'b010: begin
        nbytes = 4'd4;
        amask  = OW'(3'd3);
      end
      3'b011: begin
        if (XLEN == 64) begin
          nbytes = 4'd8;
          amask  = OW'(3'd7);
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
  end

  assign mis = |(off & amask);

  // Truncate store data to the access size before shifting into lanes
  always_comb begin
    bsel  = '0;
    dmask = '0;
    for (int i = 0; i < NB; i++) begin
      if (4'(i) < nbytes) begin
        bsel[i]       = 1'b1;
        dmask[8*i+:8] = rs2_data[8*i+:8];
      end
    end
  end

  assign be_c = bsel << off;
  assign wd_c = dmask << {off, 3'b000};
  assign tmo  = (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (in_valid) nstate = (ill || mis) ? DONE : REQ;
      REQ:  if (mem_req_ready) nstate = WAIT;
      WAIT: if (mem_resp_valid || tmo) nstate = DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done_addr <= '0;
      ill_q     <= 1'b0;
      mis_q     <= 1'b0;
      acc_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        mem_addr  <= {ea[XLEN-1:OW], {OW{1'b0}}};
        mem_wdata <= wd_c;
        mem_be    <= be_c;
        done_addr <= ea;
        ill_q     <= ill;
        mis_q     <= mis && !ill;
        acc_q     <= 1'b0;
      end
      if (state == REQ && mem_req_ready) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        // a response in the timeout cycle still reports its own status
        if (mem_resp_valid) acc_q <= mem_resp_err;
        else if (tmo)       acc_q <= 1'b1;
      end
    end
  end

  assign in_ready       = rst_n && (state == IDLE);
  assign mem_req_valid  = (state == REQ);
  assign done_valid     = (state == DONE);
  assign exc_illegal    = done_valid && ill_q;
  assign exc_misaligned = done_valid && mis_q;
  assign exc_access     = done_valid && acc_q;

endmodule
